// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic result collector.
package systolic_pkg;

   // Occupancy of one ping-pong bank.
   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_state_t;

   // Default geometry of the array this collector sits behind.
   localparam int DATAWIDTH_DEF = 16;
   localparam int N_SIZE_DEF    = 3;

   // Index width with a floor of one bit so a 1x1 array still has a legal index.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int IDX_W = idx_width(N_SIZE_DEF);
   localparam int RES_W = 2 * DATAWIDTH_DEF;

endpackage

// File: rtl/systolic_result_collector_if.sv
// Capture and drain stream signals of the result collector.
interface systolic_result_collector_if #(
   parameter int DATAWIDTH = 16,
   parameter int N_SIZE    = 3
);
   import systolic_pkg::*;

   localparam int RES_WIDTH = 2 * DATAWIDTH;
   localparam int IDX_WIDTH = idx_width(N_SIZE);

   // Capture side, driven by the systolic array.
   logic                                valid_in;
   logic [N_SIZE-1:0][RES_WIDTH-1:0]    row_in;

   // Drain side, valid/ready stream towards the consumer.
   logic                                out_valid;
   logic                                out_ready;
   logic [RES_WIDTH-1:0]                out_data;
   logic [IDX_WIDTH-1:0]                out_row;
   logic [IDX_WIDTH-1:0]                out_col;
   logic                                out_last;

   // Status back to the launcher.
   logic                                space_avail;
   logic                                overflow;

   modport master (
      output valid_in, row_in, out_ready,
      input  out_valid, out_data, out_row, out_col, out_last, space_avail, overflow
   );

   modport slave (
      input  valid_in, row_in, out_ready,
      output out_valid, out_data, out_row, out_col, out_last, space_avail, overflow
   );

endinterface

// File: rtl/collector_bank.sv
// One N x N result buffer: whole-row write port, single-element combinational read.
module collector_bank #(
   parameter int RES_WIDTH = 32,
   parameter int N_SIZE    = 3,
   parameter int IDX_WIDTH = 2
) (
   input  logic                             clk,
   input  logic                             wr_en,
   input  logic [IDX_WIDTH-1:0]             wr_row,
   input  logic [N_SIZE-1:0][RES_WIDTH-1:0] wr_data,
   input  logic [IDX_WIDTH-1:0]             rd_row,
   input  logic [IDX_WIDTH-1:0]             rd_col,
   output logic [RES_WIDTH-1:0]             rd_data
);

   logic [RES_WIDTH-1:0] mem [N_SIZE][N_SIZE];

   // Store a full result row; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < N_SIZE; c++) begin
            mem[wr_row][c] <= wr_data[c];
         end
      end
   end

   assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/systolic_result_collector.sv
// Ping-pong result collector: absorbs bursts of N rows from the systolic array
// and drains them element by element in row-major order.
module systolic_result_collector
   import systolic_pkg::*;
#(
   parameter int DATAWIDTH = 16,
   parameter int N_SIZE    = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   systolic_result_collector_if.slave   bus
);

   localparam int RES_WIDTH = 2 * DATAWIDTH;
   localparam int IDX_WIDTH = idx_width(N_SIZE);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_SIZE - 1);
   localparam logic [IDX_WIDTH-1:0] ZERO_IDX = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

   // Registered state.
   bank_state_t          bank_state [2];
   logic                 wbank;
   logic [IDX_WIDTH-1:0] wrow;
   logic                 drop_burst;
   logic                 rbank;
   logic [IDX_WIDTH-1:0] rrow;
   logic [IDX_WIDTH-1:0] rcol;
   logic                 overflow_flag;

   // Next-state values.
   bank_state_t          bank_state_next [2];
   logic                 wbank_next;
   logic [IDX_WIDTH-1:0] wrow_next;
   logic                 drop_burst_next;
   logic                 rbank_next;
   logic [IDX_WIDTH-1:0] rrow_next;
   logic [IDX_WIDTH-1:0] rcol_next;
   logic                 overflow_next;

   // Per-cycle decode.
   logic                 out_valid_int;
   logic                 at_last;
   logic                 xfer;
   logic                 free_now;
   logic                 overflow_now;
   logic                 dropping;
   logic                 write_en;
   logic                 beat_last;
   logic [RES_WIDTH-1:0] rd_data0;
   logic [RES_WIDTH-1:0] rd_data1;

   // Decode handshake, free/capture collision and whether this beat is discarded.
   always_comb begin
      out_valid_int = (bank_state[rbank] == FULL);
      at_last       = out_valid_int && (rrow == LAST_IDX) && (rcol == LAST_IDX);
      xfer          = out_valid_int && bus.out_ready;
      free_now      = xfer && at_last;
      // A bank released by this cycle's final transfer is already usable for a new burst.
      overflow_now  = bus.valid_in && (wrow == ZERO_IDX) && (bank_state[wbank] == FULL)
                      && !(free_now && (rbank == wbank));
      if (wrow == ZERO_IDX) begin
         dropping = overflow_now;
      end else begin
         dropping = drop_burst;
      end
      write_en  = bus.valid_in && !dropping;
      beat_last = bus.valid_in && (wrow == LAST_IDX);
   end

   // Next-state for bank occupancy, write pointer and read pointer.
   always_comb begin
      bank_state_next[0] = bank_state[0];
      bank_state_next[1] = bank_state[1];
      wbank_next         = wbank;
      wrow_next          = wrow;
      drop_burst_next    = drop_burst;
      rbank_next         = rbank;
      rrow_next          = rrow;
      rcol_next          = rcol;
      overflow_next      = overflow_flag || overflow_now;

      // Drain side first so a capture in the same cycle sees the freed bank.
      if (free_now) begin
         bank_state_next[rbank] = FREE;
         rbank_next             = ~rbank;
         rrow_next              = ZERO_IDX;
         rcol_next              = ZERO_IDX;
      end else if (xfer) begin
         if (rcol == LAST_IDX) begin
            rcol_next = ZERO_IDX;
            rrow_next = rrow + ONE_IDX;
         end else begin
            rcol_next = rcol + ONE_IDX;
         end
      end else begin
         rrow_next = rrow;
      end

      // Capture side: count beats, commit the bank on the last one unless dropped.
      if (bus.valid_in) begin
         if (beat_last) begin
            wrow_next       = ZERO_IDX;
            drop_burst_next = 1'b0;
            if (!dropping) begin
               bank_state_next[wbank] = FULL;
               wbank_next             = ~wbank;
            end else begin
               wbank_next = wbank;
            end
         end else begin
            wrow_next       = wrow + ONE_IDX;
            drop_burst_next = dropping;
         end
      end else begin
         wrow_next = wrow;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state[0] <= FREE;
         bank_state[1] <= FREE;
         wbank         <= 1'b0;
         wrow          <= ZERO_IDX;
         drop_burst    <= 1'b0;
         rbank         <= 1'b0;
         rrow          <= ZERO_IDX;
         rcol          <= ZERO_IDX;
         overflow_flag <= 1'b0;
      end else begin
         bank_state[0] <= bank_state_next[0];
         bank_state[1] <= bank_state_next[1];
         wbank         <= wbank_next;
         wrow          <= wrow_next;
         drop_burst    <= drop_burst_next;
         rbank         <= rbank_next;
         rrow          <= rrow_next;
         rcol          <= rcol_next;
         overflow_flag <= overflow_next;
      end
   end

   collector_bank #(
      .RES_WIDTH (RES_WIDTH),
      .N_SIZE    (N_SIZE),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_bank0 (
      .clk     (clk),
      .wr_en   (write_en && (wbank == 1'b0)),
      .wr_row  (wrow),
      .wr_data (bus.row_in),
      .rd_row  (rrow),
      .rd_col  (rcol),
      .rd_data (rd_data0)
   );

   collector_bank #(
      .RES_WIDTH (RES_WIDTH),
      .N_SIZE    (N_SIZE),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_bank1 (
      .clk     (clk),
      .wr_en   (write_en && (wbank == 1'b1)),
      .wr_row  (wrow),
      .wr_data (bus.row_in),
      .rd_row  (rrow),
      .rd_col  (rcol),
      .rd_data (rd_data1)
   );

   // Output stream is zeroed whenever nothing is presented.
   assign bus.out_valid   = out_valid_int;
   assign bus.out_last    = at_last;
   assign bus.out_data    = out_valid_int ? (rbank ? rd_data1 : rd_data0) : {RES_WIDTH{1'b0}};
   assign bus.out_row     = out_valid_int ? rrow : ZERO_IDX;
   assign bus.out_col     = out_valid_int ? rcol : ZERO_IDX;
   assign bus.space_avail = (bank_state[wbank] != FULL);
   assign bus.overflow    = overflow_flag;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for the systolic result collector: matrix-level reference
// model feeds an expected-element queue, a monitor checks the drain stream.
module tb_systolic_result_collector;

   localparam int DW = 16;
   localparam int N  = 3;
   localparam int NN = N * N;
   localparam int RW = 2 * DW;

   typedef logic [N-1:0][RW-1:0] row_t;
   typedef struct {
      logic [RW-1:0] data;
      int            row;
      int            col;
      bit            last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   systolic_result_collector_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

   systolic_result_collector #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q [$];

   // Reference model: how many complete matrices are stored, elements left in
   // the oldest one, and the progress of the burst currently arriving.
   int   m_count;
   int   m_rem;
   int   m_wrow;
   bit   m_drop;
   bit   m_overflow;
   row_t m_buf [N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic row_t mk_row(input int a, input int b, input int c);
      row_t r;
      r[0] = RW'(a);
      r[1] = RW'(b);
      r[2] = RW'(c);
      return r;
   endfunction

   task automatic model_reset();
      m_count    = 0;
      m_rem      = NN;
      m_wrow     = 0;
      m_drop     = 1'b0;
      m_overflow = 1'b0;
      exp_q.delete();
   endtask

   // One clock edge of the model, using the inputs that were stable before it.
   task automatic model_step(input bit vin, input row_t row, input bit rdy);
      exp_t e;
      if (m_count > 0 && rdy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_count--;
            m_rem = NN;
         end
      end
      if (vin) begin
         if (m_wrow == 0) begin
            m_drop = (m_count >= 2);
            if (m_drop) m_overflow = 1'b1;
         end
         m_buf[m_wrow] = row;
         if (m_wrow == N - 1) begin
            m_wrow = 0;
            if (!m_drop) begin
               m_count++;
               for (int r = 0; r < N; r++) begin
                  for (int c = 0; c < N; c++) begin
                     e.data = m_buf[r][c];
                     e.row  = r;
                     e.col  = c;
                     e.last = (r == N - 1) && (c == N - 1);
                     exp_q.push_back(e);
                  end
               end
            end
         end else begin
            m_wrow++;
         end
      end
   endtask

   task automatic cycle(input bit vin, input row_t row, input bit rdy);
      bus.valid_in  = vin;
      bus.row_in    = row;
      bus.out_ready = rdy;
      @(posedge clk);
      model_step(vin, row, rdy);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) cycle(1'b0, row_t'(0), rdy);
   endtask

   task automatic burst(input int base, input bit rdy);
      for (int r = 0; r < N; r++) begin
         cycle(1'b1, mk_row(base + 3*r + 1, base + 3*r + 2, base + 3*r + 3), rdy);
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b0;
      bus.row_in    = row_t'(0);
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   // Monitor: per-cycle status against the model, scoreboard pop on every transfer.
   initial begin
      exp_t          e;
      bit            hold;
      logic [RW-1:0] hd;
      logic [1:0]    hrow;
      logic [1:0]    hcol;
      hold = 1'b0;
      hd   = '0;
      hrow = '0;
      hcol = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            chk("out_valid", bus.out_valid, (m_count > 0));
            chk("space_avail", bus.space_avail, (m_count < 2));
            chk("overflow", bus.overflow, m_overflow);
            if (!bus.out_valid) begin
               chk("idle_outputs", {bus.out_data, bus.out_row, bus.out_col, bus.out_last}, 64'd0);
            end
            if (hold && bus.out_valid) begin
               chk("stable_data", bus.out_data, hd);
               chk("stable_index", {bus.out_row, bus.out_col}, {hrow, hcol});
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=%0h required=none at %0t", bus.out_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", bus.out_data, e.data);
                  chk("out_row", bus.out_row, e.row);
                  chk("out_col", bus.out_col, e.col);
                  chk("out_last", bus.out_last, e.last);
               end
               hold = 1'b0;
            end else if (bus.out_valid) begin
               hold = 1'b1;
               hd   = bus.out_data;
               hrow = bus.out_row;
               hcol = bus.out_col;
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      int thr;
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b0;
      bus.row_in    = row_t'(0);
      model_reset();
      do_reset();
      chk("reset_space_avail", bus.space_avail, 1'b1);
      chk("reset_out_valid", bus.out_valid, 1'b0);

      // Single matrix with a always-ready consumer.
      burst(0, 1'b1);
      chk("latency_valid", bus.out_valid, 1'b1);
      chk("first_element", bus.out_data, 32'd1);
      idle(12, 1'b1);
      chk("single_drained", exp_q.size(), 0);

      // Back-pressure: ready pattern 1,0,0,1,...
      for (int i = 0; i < 40; i++) begin
         cycle(i < N, (i < N) ? mk_row(3*i + 1, 3*i + 2, 3*i + 3) : row_t'(0), (i % 3) == 0);
      end
      chk("backpressure_drained", exp_q.size(), 0);

      // Ping-pong fill, then a third burst that must be dropped.
      burst(0, 1'b0);
      burst(9, 1'b0);
      idle(2, 1'b0);
      chk("pingpong_full", bus.space_avail, 1'b0);
      burst(100, 1'b0);
      idle(2, 1'b0);
      chk("overflow_set", bus.overflow, 1'b1);
      idle(25, 1'b1);
      chk("overflow_drained", exp_q.size(), 0);
      chk("overflow_sticky", bus.overflow, 1'b1);

      // Final transfer of bank 0 coincides with the first beat targeting bank 0.
      do_reset();
      burst(0, 1'b0);
      burst(9, 1'b0);
      idle(NN - 1, 1'b1);
      cycle(1'b1, mk_row(201, 202, 203), 1'b1);
      cycle(1'b1, mk_row(204, 205, 206), 1'b1);
      cycle(1'b1, mk_row(207, 208, 209), 1'b1);
      idle(25, 1'b1);
      chk("collision_no_overflow", bus.overflow, 1'b0);
      chk("collision_drained", exp_q.size(), 0);

      // Reset in the middle of a burst, then a fresh burst.
      cycle(1'b1, mk_row(71, 72, 73), 1'b1);
      cycle(1'b1, mk_row(74, 75, 76), 1'b1);
      do_reset();
      burst(50, 1'b1);
      idle(12, 1'b1);
      chk("midburst_no_overflow", bus.overflow, 1'b0);
      chk("midburst_drained", exp_q.size(), 0);

      // Randomized traffic with varying consumer pressure.
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         thr = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 6 : 10);
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 199) == 0) begin
               do_reset();
            end else begin
               cycle($urandom_range(0, 3) != 0, mk_row($urandom, $urandom, $urandom),
                     $urandom_range(0, 9) < thr);
            end
         end
      end
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
         cycle(1'b0, row_t'(0), 1'b1);
      end
      chk("final_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
